// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: round-robin anode scan with blanking gaps for a multi-digit seven-segment display.
// Define SSEG_SCAN_DP_EN to add a per-digit decimal-point store (wr_dp in, dp_n out).
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [4:0]                    wr_data,
`ifdef SSEG_SCAN_DP_EN
    input  logic                          wr_dp,
    output logic                          dp_n,
`endif
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    output logic [4:0]                    code_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic                          frame_tick
);
    localparam int MAXC = REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES;
    localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [0:0] SHOW = 1'b0;
    localparam logic [0:0] GAP = 1'b1;
    localparam logic [4:0] BLANK = 5'h13;
    localparam logic [TW-1:0] SHOW_END = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] GAP_END = TW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    logic [0:0]            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4:0]            store_q [NUM_DIGITS];
    logic [4:0]            store_d [NUM_DIGITS];
    logic [4:0]            code_q, code_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;
    logic                  lit, slot_end;

    always_comb begin
        lit = state_q == SHOW && digit_mask[idx_q];
        slot_end = timer_q == (state_q == SHOW ? SHOW_END : GAP_END);
        timer_d = slot_end ? '0 : timer_q + 1'b1;
        state_d = slot_end ? ~state_q : state_q;
        idx_d = slot_end && state_q == GAP ? (idx_q == LAST ? '0 : idx_q + 1'b1) : idx_q;
        an_d = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        code_d = state_q == SHOW ? store_q[idx_q] : BLANK;
        tick_d = state_q == SHOW && idx_q == '0 && timer_q == '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            store_d[i] = wr_en && wr_addr == IW'(i) ? wr_data : store_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SHOW;
            timer_q <= '0;
            idx_q <= '0;
            code_q <= BLANK;
            an_q <= '1;
            tick_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) store_q[i] <= BLANK;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q <= idx_d;
            code_q <= code_d;
            an_q <= an_d;
            tick_q <= tick_d;
            store_q <= store_d;
        end
    end

    assign code_out = code_q;
    assign an_n = an_q;
    assign frame_tick = tick_q;

`ifdef SSEG_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] dps_q, dps_d;
    logic                  dpn_q, dpn_d;

    always_comb begin
        dpn_d = lit ? ~dps_q[idx_q] : 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            dps_d[i] = wr_en && wr_addr == IW'(i) ? wr_dp : dps_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dps_q <= '0;
            dpn_q <= 1'b1;
        end else begin
            dps_q <= dps_d;
            dpn_q <= dpn_d;
        end
    end

    assign dp_n = dpn_q;
`endif
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: table-driven stimulus with a frame-position model feeding a per-cycle scoreboard.
module tb_sseg_scan_ctrl;
    logic       clk = 0, rst = 1, wr_en = 0, wr_dp = 0;
    logic [1:0] wr_addr = 0;
    logic [4:0] wr_data = 0, code_out;
    logic [3:0] digit_mask = 4'hF, an_n;
    logic       frame_tick, dp_n;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef SSEG_SCAN_DP_EN
        .wr_dp(wr_dp), .dp_n(dp_n),
`endif
        .digit_mask(digit_mask), .code_out(code_out), .an_n(an_n), .frame_tick(frame_tick)
    );
`ifndef SSEG_SCAN_DP_EN
    assign dp_n = 1'b1;
`endif

    typedef struct packed {logic [3:0] an; logic [4:0] code; logic tick; logic dp;} exp_t;
    typedef struct {logic r; logic we; logic [1:0] wa; logic [4:0] wd; logic [3:0] m; logic dp; int n;} step_t;

    exp_t       sb[$];
    logic [4:0] mstore [4];
    logic [3:0] mdp;
    int         pos = 0, errors = 0, checks = 0, cyc_no = 0, last_tick = -1;
    step_t      tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc_no, act, req);
        end
    endtask

    // Expected output is computed from model state before the edge, then the edge's write lands.
    task automatic cyc(input logic r, input logic we, input logic [1:0] wa, input logic [4:0] wd,
                       input logic [3:0] m, input logic dp);
        exp_t e, got;
        int slot, w;
        logic show;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; digit_mask = m; wr_dp = dp;
        if (r) begin
            e = '{4'hF, 5'h13, 1'b0, 1'b1};
            for (int i = 0; i < 4; i++) mstore[i] = 5'h13;
            mdp = '0;
            pos = 0;
        end else begin
            slot = pos / 6; w = pos % 6; show = w < 4;
            e.an = show && m[slot] ? ~(4'b1 << slot) : 4'hF;
            e.code = show ? mstore[slot] : 5'h13;
            e.tick = pos == 0;
`ifdef SSEG_SCAN_DP_EN
            e.dp = show && m[slot] ? ~mdp[slot] : 1'b1;
`else
            e.dp = 1'b1;
`endif
            if (we) begin mstore[wa] = wd; mdp[wa] = dp; end
            pos = (pos + 1) % 24;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        cyc_no++;
        e = sb.pop_front();
        got = '{an_n, code_out, frame_tick, dp_n};
        check("an_n", 32'(got.an), 32'(e.an));
        check("code_out", 32'(got.code), 32'(e.code));
        check("frame_tick", 32'(got.tick), 32'(e.tick));
        check("dp_n", 32'(got.dp), 32'(e.dp));
        if (got.tick && !r) begin
            if (last_tick >= 0) check("tick_period", 32'(cyc_no - last_tick), 32'd24);
            last_tick = cyc_no;
        end
        if (r) last_tick = -1;
        @(negedge clk);
    endtask

    task automatic idle_until(input int p, input logic [3:0] m);
        int guard = 0;
        while (pos != p && guard < 100) begin cyc(0, 0, 0, 0, m, 0); guard++; end
        check("align_timeout", 32'(pos), 32'(p));
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 5'h00, 4'hF, 0, 2};
        tbl[1] = '{0, 0, 0, 5'h00, 4'hF, 0, 48};
        tbl[2] = '{0, 1, 0, 5'h00, 4'hF, 1, 1};
        tbl[3] = '{0, 1, 1, 5'h01, 4'hF, 0, 1};
        tbl[4] = '{0, 1, 2, 5'h02, 4'hF, 0, 1};
        tbl[5] = '{0, 1, 3, 5'h03, 4'hF, 0, 1};
        tbl[6] = '{0, 0, 0, 5'h00, 4'hF, 0, 30};
        tbl[7] = '{0, 0, 0, 5'h00, 4'b1011, 0, 24};
        @(negedge clk);
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < tbl[s].n; k++)
                cyc(tbl[s].r, tbl[s].we, tbl[s].wa, tbl[s].wd, tbl[s].m, tbl[s].dp);

        // Write to the digit being shown: old value one more cycle, then the new one.
        idle_until(8, 4'hF);
        cyc(0, 1, 1, 5'h0A, 4'hF, 0);
        check("wr_old_code", 32'(code_out), 32'h01);
        check("wr_an_steady", 32'(an_n), 32'hD);
        cyc(0, 0, 0, 0, 4'hF, 0);
        check("wr_new_code", 32'(code_out), 32'h0A);
        cyc(0, 1, 3, 5'h1F, 4'hF, 0);
        for (int k = 0; k < 24; k++) cyc(0, 0, 0, 0, 4'hF, 0);

        // Reset in the middle of idx 2's slot.
        idle_until(14, 4'hF);
        cyc(1, 0, 0, 0, 4'hF, 0);
        check("rst_an", 32'(an_n), 32'hF);
        check("rst_code", 32'(code_out), 32'h13);
        cyc(0, 0, 0, 0, 4'hF, 0);
        check("restart_tick", 32'(frame_tick), 32'd1);
        check("restart_an", 32'(an_n), 32'hE);
        for (int k = 0; k < 30; k++) cyc(0, 0, 0, 0, 4'hF, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
